// File: rtl/wb_arbiter_pipelined.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between several pipelined masters.
// Holds the grant until every accepted strobe has been acked, and throttles at MAX_OUT in flight.
module wb_arbiter_pipelined #(
    parameter int NUM_MASTERS = 2,
    parameter int ADR_W       = 16,
    parameter int DAT_W       = 16,
    parameter int MAX_OUT     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_MASTERS-1:0]       m_cyc,
    input  logic [NUM_MASTERS-1:0]       m_stb,
    input  logic [NUM_MASTERS-1:0]       m_we,
    input  logic [NUM_MASTERS*ADR_W-1:0] m_adr,
    input  logic [NUM_MASTERS*DAT_W-1:0] m_dat_i,
    output logic [DAT_W-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]       m_ack,
    output logic [NUM_MASTERS-1:0]       m_stall,
    output logic                         s_cyc,
    output logic                         s_stb,
    output logic                         s_we,
    output logic [ADR_W-1:0]             s_adr,
    output logic [DAT_W-1:0]             s_dat_o,
    input  logic [DAT_W-1:0]             s_dat_i,
    input  logic                         s_ack,
    input  logic                         s_stall,
    output logic [NUM_MASTERS-1:0]       gnt
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [NUM_MASTERS-1:0] gnt_r, gnt_s;
    logic [IDX_W-1:0]       gidx_r, gidx_s;
    logic [IDX_W-1:0]       last_r, last_s;
    logic [CNT_W-1:0]       outstanding_r, outstanding_s;

    logic                   win_found_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic [IDX_W-1:0]       cand_s;
    logic                   full_s;
    logic                   stb_s;
    logic                   accept_s;
    logic                   ack_fwd_s;

    assign full_s  = (outstanding_r == CNT_W'(MAX_OUT));
    assign gnt     = gnt_r;
    assign s_stb   = stb_s;
    assign m_dat_o = s_dat_i;

    // Round-robin pick: first requesting master after the last one served.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        cand_s      = {IDX_W{1'b0}};
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand_s = IDX_W'((32'(last_r) + k) % NUM_MASTERS);
            if (!win_found_s && m_cyc[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Slave-side mux and master-side stall/ack, combinational from the grant register.
    always_comb begin
        s_cyc     = 1'b0;
        stb_s     = 1'b0;
        s_we      = 1'b0;
        s_adr     = {ADR_W{1'b0}};
        s_dat_o   = {DAT_W{1'b0}};
        m_ack     = {NUM_MASTERS{1'b0}};
        m_stall   = {NUM_MASTERS{1'b1}};
        accept_s  = 1'b0;
        ack_fwd_s = 1'b0;
        case (state_r)
            ST_GRANT: begin
                s_cyc           = 1'b1;
                stb_s           = m_stb[gidx_r] & ~full_s;
                s_we            = m_we[gidx_r];
                s_adr           = m_adr[32'(gidx_r) * ADR_W +: ADR_W];
                s_dat_o         = m_dat_i[32'(gidx_r) * DAT_W +: DAT_W];
                m_stall[gidx_r] = s_stall | full_s;
                accept_s        = stb_s & ~s_stall;
                // An ack with nothing in flight is a slave protocol error and is dropped.
                ack_fwd_s       = s_ack & (outstanding_r != {CNT_W{1'b0}});
                m_ack[gidx_r]   = ack_fwd_s;
            end
            ST_DRAIN: begin
                s_cyc         = 1'b1;
                s_we          = m_we[gidx_r];
                s_adr         = m_adr[32'(gidx_r) * ADR_W +: ADR_W];
                s_dat_o       = m_dat_i[32'(gidx_r) * DAT_W +: DAT_W];
                ack_fwd_s     = s_ack & (outstanding_r != {CNT_W{1'b0}});
                m_ack[gidx_r] = ack_fwd_s;
            end
            default: begin
                s_cyc = 1'b0;
            end
        endcase
    end

    // Outstanding-transfer counter: accept and ack in one cycle cancel out.
    always_comb begin
        outstanding_s = outstanding_r;
        case ({accept_s, ack_fwd_s})
            2'b10:   outstanding_s = outstanding_r + CNT_W'(1);
            2'b01:   outstanding_s = outstanding_r - CNT_W'(1);
            default: outstanding_s = outstanding_r;
        endcase
    end

    // Next-state logic; the grant is released only once the counter reaches zero.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        gidx_s  = gidx_r;
        last_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_s = ST_GRANT;
                    gidx_s  = win_idx_s;
                    gnt_s   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_idx_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!m_cyc[gidx_r]) begin
                    if (outstanding_s == {CNT_W{1'b0}}) begin
                        state_s = ST_IDLE;
                        last_s  = gidx_r;
                        gnt_s   = {NUM_MASTERS{1'b0}};
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else begin
                    state_s = ST_GRANT;
                end
            end
            ST_DRAIN: begin
                if (outstanding_s == {CNT_W{1'b0}}) begin
                    state_s = ST_IDLE;
                    last_s  = gidx_r;
                    gnt_s   = {NUM_MASTERS{1'b0}};
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = {NUM_MASTERS{1'b0}};
            end
        endcase
    end

    // State registers with synchronous reset; last starts at the top so master 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            gnt_r         <= {NUM_MASTERS{1'b0}};
            gidx_r        <= {IDX_W{1'b0}};
            last_r        <= IDX_W'(NUM_MASTERS - 1);
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_s;
            gnt_r         <= gnt_s;
            gidx_r        <= gidx_s;
            last_r        <= last_s;
            outstanding_r <= outstanding_s;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_pipelined.sv
// Directed bench for wb_arbiter_pipelined: a MAX_OUT=4 instance plus a MAX_OUT=2 instance
// sharing the same stimulus for the throttle scenario.
module tb_wb_arbiter_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [31:0] m_adr, m_dat_i;
    logic [15:0] m_dat_o, s_adr, s_dat_o, s_dat_i;
    logic [1:0]  m_ack, m_stall, gnt;
    logic        s_cyc, s_stb, s_we, s_ack, s_stall;

    logic [15:0] m_dat_o2, s_adr2, s_dat_o2;
    logic [1:0]  m_ack2, m_stall2, gnt2;
    logic        s_cyc2, s_stb2, s_we2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_arbiter_pipelined #(.NUM_MASTERS(2), .ADR_W(16), .DAT_W(16), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack(m_ack),
        .m_stall(m_stall), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_adr(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack),
        .s_stall(s_stall), .gnt(gnt)
    );

    wb_arbiter_pipelined #(.NUM_MASTERS(2), .ADR_W(16), .DAT_W(16), .MAX_OUT(2)) dut2 (
        .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o2), .m_ack(m_ack2),
        .m_stall(m_stall2), .s_cyc(s_cyc2), .s_stb(s_stb2), .s_we(s_we2),
        .s_adr(s_adr2), .s_dat_o(s_dat_o2), .s_dat_i(s_dat_i), .s_ack(s_ack),
        .s_stall(s_stall), .gnt(gnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, then settle before checking.
    task automatic step(input logic [1:0] cyc, input logic [1:0] stb, input logic ack);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_cyc = cyc;
        m_stb = stb;
        s_ack = ack;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        m_cyc = 2'b00;
        m_stb = 2'b00;
        s_ack = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        m_cyc   = 2'b00;
        m_stb   = 2'b00;
        m_we    = 2'b00;
        m_adr   = 32'h5678_1234;
        m_dat_i = 32'hD1D1_D0D0;
        s_dat_i = 16'hBEEF;
        s_ack   = 1'b0;
        s_stall = 1'b0;

        // Single master, four reads on a zero-wait slave
        do_reset();
        step(2'b01, 2'b01, 1'b0);
        chk("rst_state", 32'(dut.state_r), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc), 32'h0);
        chk("rst_s_stb", 32'(s_stb), 32'h0);
        chk("rst_m_ack", 32'(m_ack), 32'h0);
        chk("rst_m_stall", 32'(m_stall), 32'h3);
        chk("rst_outst", 32'(dut.outstanding_r), 32'h0);
        step(2'b01, 2'b01, 1'b0);
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_s_stb0", 32'(s_stb), 32'h1);
        chk("single_stall", 32'(m_stall), 32'h2);
        chk("single_adr", 32'(s_adr), 32'h1234);
        chk("single_dat_o", 32'(s_dat_o), 32'hD0D0);
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 2'b01, 1'b1);
            chk("single_s_stb", 32'(s_stb), 32'h1);
            chk("single_ack", 32'(m_ack), 32'h1);
        end
        chk("single_rdata", 32'(m_dat_o), 32'hBEEF);
        step(2'b00, 2'b00, 1'b1);
        chk("single_last_ack", 32'(m_ack), 32'h1);
        chk("single_outst_1", 32'(dut.outstanding_r), 32'h1);
        step(2'b00, 2'b00, 1'b0);
        chk("single_idle", 32'(dut.state_r), 32'd0);
        chk("single_outst_0", 32'(dut.outstanding_r), 32'h0);
        chk("single_s_cyc_off", 32'(s_cyc), 32'h0);

        // Contention, plus a spurious ack while nothing is outstanding
        do_reset();
        m_we = 2'b01;
        step(2'b11, 2'b00, 1'b0);
        step(2'b11, 2'b00, 1'b1);
        chk("cont_gnt_m0", 32'(gnt), 32'h1);
        chk("cont_stall", 32'(m_stall), 32'h2);
        chk("cont_we", 32'(s_we), 32'h1);
        chk("spurious_ack", 32'(m_ack), 32'h0);
        step(2'b10, 2'b00, 1'b0);
        chk("spurious_outst", 32'(dut.outstanding_r), 32'h0);
        chk("cont_m1_stall", 32'(m_stall[1]), 32'h1);
        step(2'b10, 2'b00, 1'b0);
        chk("cont_idle_gnt", 32'(gnt), 32'h0);
        step(2'b10, 2'b00, 1'b0);
        chk("cont_gnt_m1", 32'(gnt), 32'h2);
        chk("cont_adr_m1", 32'(s_adr), 32'h5678);
        chk("cont_we_m1", 32'(s_we), 32'h0);
        m_we = 2'b00;

        // Fairness: both keep requesting, each tenure is two transfers
        do_reset();
        step(2'b11, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] gb;
            gb = (i % 2 == 0) ? 2'b01 : 2'b10;
            step(2'b11, 2'b11, 1'b0);
            chk("fair_gnt", 32'(gnt), 32'(gb));
            chk("fair_stb", 32'(s_stb), 32'h1);
            step(2'b11, 2'b11, 1'b1);
            chk("fair_ack1", 32'(m_ack), 32'(gb));
            step(~gb, ~gb, 1'b1);
            chk("fair_ack2", 32'(m_ack), 32'(gb));
            step(2'b11, 2'b11, 1'b0);
            chk("fair_gap", 32'(gnt), 32'h0);
        end

        // Throttle on the MAX_OUT=2 instance
        do_reset();
        step(2'b01, 2'b01, 1'b0);
        step(2'b01, 2'b01, 1'b0);
        chk("thr_stb1", 32'(s_stb2), 32'h1);
        chk("thr_stall_open", 32'(m_stall2), 32'h2);
        step(2'b01, 2'b01, 1'b0);
        chk("thr_stb2", 32'(s_stb2), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 2'b01, 1'b0);
            chk("thr_gated", 32'(s_stb2), 32'h0);
            chk("thr_stalled", 32'(m_stall2), 32'h3);
            chk("thr_outst", 32'(dut2.outstanding_r), 32'h2);
        end
        step(2'b01, 2'b01, 1'b1);
        chk("thr_ack_full", 32'(s_stb2), 32'h0);
        chk("thr_ack", 32'(m_ack2), 32'h1);
        step(2'b01, 2'b01, 1'b0);
        chk("thr_reopen", 32'(s_stb2), 32'h1);
        chk("thr_outst_1", 32'(dut2.outstanding_r), 32'h1);

        // Drain: three in flight when cyc drops, one-wait slave
        do_reset();
        step(2'b11, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 2'b01, 1'b0);
            chk("drain_accept", 32'(s_stb), 32'h1);
        end
        step(2'b10, 2'b00, 1'b0);
        chk("drain_pre_outst", 32'(dut.outstanding_r), 32'h3);
        for (int j = 0; j < 3; j++) begin
            step(2'b10, 2'b01, 1'b1);
            chk("drain_state", 32'(dut.state_r), 32'd2);
            chk("drain_s_cyc", 32'(s_cyc), 32'h1);
            chk("drain_s_stb", 32'(s_stb), 32'h0);
            chk("drain_ack", 32'(m_ack), 32'h1);
            chk("drain_stall", 32'(m_stall), 32'h3);
            chk("drain_gnt_held", 32'(gnt), 32'h1);
            step(2'b10, 2'b01, 1'b0);
            chk("drain_gap_ack", 32'(m_ack), 32'h0);
            chk("drain_gnt_after", 32'(gnt), (j == 2) ? 32'h0 : 32'h1);
        end
        step(2'b10, 2'b00, 1'b0);
        chk("drain_next_m1", 32'(gnt), 32'h2);

        // Reset in the middle of a burst
        do_reset();
        step(2'b01, 2'b01, 1'b0);
        step(2'b01, 2'b01, 1'b0);
        step(2'b01, 2'b01, 1'b0);
        chk("mid_outst_1", 32'(dut.outstanding_r), 32'h1);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        m_stb = 2'b00;
        #1;
        chk("mid_outst_2", 32'(dut.outstanding_r), 32'h2);
        step(2'b11, 2'b00, 1'b1);
        chk("mid_gnt", 32'(gnt), 32'h0);
        chk("mid_s_cyc", 32'(s_cyc), 32'h0);
        chk("mid_outst_0", 32'(dut.outstanding_r), 32'h0);
        chk("mid_late_ack", 32'(m_ack), 32'h0);
        step(2'b11, 2'b00, 1'b0);
        chk("mid_regrant_m0", 32'(gnt), 32'h1);
        chk("mid_outst_stay", 32'(dut.outstanding_r), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_pipelined.md
Name: wb_arbiter_pipelined

Overview:
Round-robin arbiter sharing one pipelined Wishbone slave (e.g. the 64Kx16 RAM slave) between NUM_MASTERS pipelined masters. It grants the bus for a whole cycle (cyc high) and muxes the granted master onto the slave port. It counts outstanding strobes so the grant is released only after every ack has returned, and it throttles a master that reaches MAX_OUT outstanding transfers.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADR_W, 16, address width
DAT_W, 16, data width
MAX_OUT, 4, max accepted-but-unacked strobes (1..15)

Ports:
clk  in  1  bus clock
rst  in  1  synchronous active-high reset
m_cyc  in  NUM_MASTERS  per-master cyc
m_stb  in  NUM_MASTERS  per-master stb
m_we  in  NUM_MASTERS  per-master write enable
m_adr  in  NUM_MASTERS*ADR_W  packed addresses; master i at [i*ADR_W +: ADR_W]
m_dat_i  in  NUM_MASTERS*DAT_W  packed write data
m_dat_o  out  DAT_W  read data, broadcast from s_dat_i
m_ack  out  NUM_MASTERS  per-master ack
m_stall  out  NUM_MASTERS  per-master stall
s_cyc  out  1  slave cyc
s_stb  out  1  slave stb
s_we  out  1  slave we
s_adr  out  ADR_W  slave address
s_dat_o  out  DAT_W  slave write data
s_dat_i  in  DAT_W  slave read data
s_ack  in  1  slave ack
s_stall  in  1  slave stall
gnt  out  NUM_MASTERS  one-hot registered grant; debug/monitor

Behaviour:
- Reset: state=IDLE, gnt=0, outstanding=0, last=NUM_MASTERS-1 (master 0 wins first). s_cyc=s_stb=0, all m_ack=0, all m_stall=1.
- State IDLE: s_cyc=0, s_stb=0, all m_stall=1.
  - If any m_cyc, select the first set m_cyc scanning last+1, last+2, ... with wrap-around.
  - Register gnt and move to GRANT. Arbitration latency is one clock from cyc to grant.
- State GRANT, granted master g:
  - s_cyc=1, s_we=m_we[g], s_adr/s_dat_o = master g's slices.
  - s_stb = m_stb[g] & ~full, where full = (outstanding==MAX_OUT).
  - m_stall[g] = s_stall | full. accept = s_stb & ~s_stall.
  - m_ack[g] = s_ack & (outstanding!=0).
  - Non-granted masters: m_stall=1, m_ack=0.
- Leaving GRANT:
  - m_cyc[g] low and outstanding==0 (counting the ack this cycle): go to IDLE, set last=g, clear gnt.
  - m_cyc[g] low and outstanding still >0: go to DRAIN.
- State DRAIN: s_cyc=1, s_stb=0, acks still forwarded to g. When the final ack arrives, go to IDLE, set last=g, clear gnt.
- There is always one idle cycle between grants, so master changes never overlap on the slave.
- Outstanding counter:
  - Width $clog2(MAX_OUT+1).
  - +1 on accept, -1 on forwarded ack; accept and ack in the same cycle leave it unchanged.
  - Never exceeds MAX_OUT, because s_stb is gated by full.
- s_ack with outstanding==0 is a protocol error: the ack is dropped, not forwarded, and the counter stays 0 (no underflow).
- m_dat_o = s_dat_i, combinational and unqualified; masters qualify it with m_ack.
- Reset mid-burst: on the next edge everything returns to reset values; in-flight acks are discarded.
- Slave-side outputs are combinational from the gnt register and master inputs; there is no extra pipeline latency on stb/ack paths.

Test Plan:
- Single master: m0 issues 4 read stbs, slave with 0 waitcycles. Required: s_stb high 4 consecutive cycles from grant+0; m_ack[0] one cycle after each; outstanding returns to 0; IDLE one cycle after cyc drops.
- Contention: m0 and m1 raise cyc in the same cycle after reset. Required: gnt=01 first; gnt=10 two cycles after m0 drops cyc (GRANT to IDLE, then arbitrate); m1 stall=1 throughout m0's tenure.
- Fairness: both masters hold cyc continuously, each releasing after 2 transfers. Required: grants alternate 01,10,01,10; no master is granted twice in a row.
- Throttle: MAX_OUT=2, slave acks held off 5 cycles, m0 asserts stb continuously. Required: exactly 2 accepts, then m_stall[0]=1 and s_stb=0 until the first ack; outstanding never exceeds 2.
- Drain: m0 drops cyc with 3 outstanding on a slave with 1 waitcycle. Required: state DRAIN, s_cyc=1, s_stb=0, three m_ack[0] pulses, then IDLE; m1 not granted before the third ack.
- Reset mid-burst: assert rst with 2 outstanding. Required: next cycle gnt=0, s_cyc=0, outstanding=0; late s_ack is not forwarded; master 0 wins the next arbitration.
